kapisma_hamle_toplayici: RTL
============================

Name: kapisma_hamle_toplayici

Overview:
Sequential front end that produces the inputs of the combinational kapisma block and consumes its outputs.
- Collects right/down step presses for three players in turn and packs them into sag_adimlar/asagi_adimlar.
- Latches a secret number, presents the round with a valid/ack handshake, then adds the returned toplam_puan to the winner's running score.

Parameters:
- MAKS_ADIM, 2: maximum steps per direction per player; presses beyond it saturate.
- SKOR_W, 8: width of each player's score register.
- ZAMAN_ASIMI, 1000: idle cycles before an automatic confirm. Used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- basla  input  1  one-cycle pulse; starts a round.
- sag_bas  input  1  one-cycle pulse; one right step for the active player.
- asagi_bas  input  1  one-cycle pulse; one down step for the active player.
- onay  input  1  one-cycle pulse; active player confirms.
- sag_adimlar  output  6  packed right steps: P1 [5:4], P2 [3:2], P3 [1:0].
- asagi_adimlar  output  6  packed down steps, same packing.
- sayi  output  4  secret number, 1..9, held for the whole round.
- gecerli  output  1  round outputs valid.
- sonuc_al  input  1  consumer ack; kazanan/toplam_puan are valid in the same cycle.
- kazanan  input  2  0 = none, 1..3 = winning player.
- toplam_puan  input  5  points for the round.
- aktif_oyuncu  output  2  0 = none, 1..3 = player currently entering.
- skor1, skor2, skor3  output  SKOR_W  running scores.
- mesgul  output  1  high in every state except BOSTA.

Behaviour:
- Reset:
  - All outputs are 0, state is BOSTA, scores are 0.
  - The sayi counter resets to 1; sayi output resets to 0.
  - Reset mid-round discards the round and clears the scores.
- Free-running counter sayac cycles 1,2,…,9,1 every clock, including while not in BOSTA.
- BOSTA:
  - On basla: latch sayi <= sayac, clear both step vectors, aktif_oyuncu <= 1, go to GIRIS.
  - Presses and onay are ignored.
- GIRIS:
  - sag_bas increments the active player's 2-bit right field, saturating at MAKS_ADIM. asagi_bas does the same for the down field.
  - Both presses in one cycle increment both fields.
  - onay in the same cycle as a press: the press is applied first, then the commit happens.
  - On onay with aktif_oyuncu < 3: aktif_oyuncu increments, and the next player's fields stay 0.
  - On onay with aktif_oyuncu = 3: go to HAZIR, aktif_oyuncu <= 0.
  - basla is ignored.
- HAZIR:
  - gecerli = 1. sag_adimlar, asagi_adimlar and sayi are stable until sonuc_al.
  - Presses, onay and basla are ignored.
  - On sonuc_al: if kazanan ≠ 0, skor[kazanan] <= min(skor + toplam_puan, 2^SKOR_W − 1); if kazanan = 0, no score change.
  - After sonuc_al: gecerli drops the next cycle, state goes to BOSTA.
  - Handshake latency: first gecerli-high cycle is the cycle after the final onay. Scores update in the cycle after sonuc_al.
- Outputs are registered. Step vectors and sayi keep their last values in BOSTA until the next basla.
- Score addition: zero-extend toplam_puan to SKOR_W + 1 bits, then saturate.

Optional Feature:
- Macro: KAPISMA_ZAMAN_ASIMI_EN.
- When defined:
  - A per-player idle counter counts cycles in GIRIS without sag_bas, asagi_bas or onay.
  - When it reaches ZAMAN_ASIMI, the block performs an implicit onay with the current fields.
  - Any press or onay restarts the counter from 0.
  - The counter clears on every player change.
- When undefined: no counter logic; the block waits in GIRIS indefinitely.

Decomposition:
- Shared package kapisma_pkg:
  - State encoding: BOSTA, GIRIS, HAZIR.
  - Field widths: ADIM_W = 2, SAYI_W = 4, PUAN_W = 5.
  - SAYI_MIN = 1, SAYI_MAX = 9.
  - Field offsets per player (P1 = 4, P2 = 2, P3 = 0).
- One natural sub-module: kapisma_skor_sayaci, a saturating SKOR_W accumulator with enable, instantiated three times.

Test Plan:
1. rst high 3 cycles mid-GIRIS, then low -> all outputs 0, mesgul = 0, scores 0; sayi stays 0 until the next basla.
2. basla; P1 sag ×1, asagi ×2, onay; P2 onay; P3 sag ×2, onay -> next cycle gecerli = 1, sag_adimlar = 6'b01_00_10, asagi_adimlar = 6'b10_00_00, aktif_oyuncu = 0.
3. In GIRIS, P1 sag_bas ×5 -> field saturates at 2; a sag_bas + asagi_bas + onay in one cycle yields fields 2/1 and moves to P2.
4. HAZIR, sonuc_al with kazanan = 3, toplam_puan = 17 -> skor3 = 17 next cycle, gecerli = 0, state BOSTA. Repeated with skor3 = 250 and toplam_puan = 10 -> skor3 = 255.
5. HAZIR held 20 cycles with no sonuc_al while toggling sag_bas/basla -> outputs unchanged. sonuc_al with kazanan = 0 -> no score changes.
6. With KAPISMA_ZAMAN_ASIMI_EN and ZAMAN_ASIMI = 8: basla, P1 one press, then idle 8 cycles -> aktif_oyuncu = 2. Without the macro, idle 100 cycles -> aktif_oyuncu stays 1.

Source files
------------

// File: rtl/kapisma_pkg.sv
// Shared types and field layout for the kapisma move collector.
// Optional idle timeout is enabled with KAPISMA_ZAMAN_ASIMI_EN.
package kapisma_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        GIRIS = 2'd1,
        HAZIR = 2'd2
    } durum_e;

    localparam int ADIM_W = 2;
    localparam int SAYI_W = 4;
    localparam int PUAN_W = 5;

    localparam logic [SAYI_W-1:0] SAYI_MIN = 4'd1;
    localparam logic [SAYI_W-1:0] SAYI_MAX = 4'd9;

    localparam int OFS_P1 = 4;
    localparam int OFS_P2 = 2;
    localparam int OFS_P3 = 0;

    function automatic int alan_ofs(input logic [1:0] oyuncu);
        int ofs;
        case (oyuncu)
            2'd1:    ofs = OFS_P1;
            2'd2:    ofs = OFS_P2;
            default: ofs = OFS_P3;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/kapisma_skor_sayaci.sv
// Saturating score accumulator; adds a round's points when enabled.
module kapisma_skor_sayaci
    import kapisma_pkg::*;
#(
    parameter int SKOR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PUAN_W-1:0] ekle,
    output logic [SKOR_W-1:0] skor
);

    logic [SKOR_W-1:0] skor_q;
    logic [SKOR_W-1:0] skor_d;
    logic [SKOR_W:0]   toplam;

    always_comb begin
        toplam = {1'b0, skor_q} + {{(SKOR_W + 1 - PUAN_W){1'b0}}, ekle};
        skor_d = toplam[SKOR_W] ? {SKOR_W{1'b1}} : toplam[SKOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skor_q <= '0;
        end else if (en) begin
            skor_q <= skor_d;
        end
    end

    assign skor = skor_q;

endmodule

// File: rtl/kapisma_hamle_toplayici.sv
// Collects three players' steps, presents the round, accumulates scores.
// Define KAPISMA_ZAMAN_ASIMI_EN for the automatic confirm after idle time.
module kapisma_hamle_toplayici
    import kapisma_pkg::*;
#(
    parameter int MAKS_ADIM   = 2,
    parameter int SKOR_W      = 8,
    parameter int ZAMAN_ASIMI = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              basla,
    input  logic              sag_bas,
    input  logic              asagi_bas,
    input  logic              onay,
    output logic [5:0]        sag_adimlar,
    output logic [5:0]        asagi_adimlar,
    output logic [SAYI_W-1:0] sayi,
    output logic              gecerli,
    input  logic              sonuc_al,
    input  logic [1:0]        kazanan,
    input  logic [PUAN_W-1:0] toplam_puan,
    output logic [1:0]        aktif_oyuncu,
    output logic [SKOR_W-1:0] skor1,
    output logic [SKOR_W-1:0] skor2,
    output logic [SKOR_W-1:0] skor3,
    output logic              mesgul
);

    localparam logic [ADIM_W-1:0] MAKS = ADIM_W'(MAKS_ADIM);

    durum_e            durum_q;
    logic [5:0]        sag_q, sag_d;
    logic [5:0]        asagi_q, asagi_d;
    logic [SAYI_W-1:0] sayac_q;
    logic [SAYI_W-1:0] sayi_q;
    logic [1:0]        aktif_q;
    logic              gecerli_q;
    logic              mesgul_q;
    logic              zaman_doldu;
    logic              kabul;
    logic [2:0]        skor_en;
    logic [ADIM_W-1:0] sag_alan, asagi_alan;
    int                ofs;

    // Press is folded into the field before any commit in the same cycle.
    always_comb begin
        ofs        = alan_ofs(aktif_q);
        sag_alan   = sag_q[ofs +: ADIM_W];
        asagi_alan = asagi_q[ofs +: ADIM_W];
        sag_d      = sag_q;
        asagi_d    = asagi_q;
        if (sag_bas && (sag_alan < MAKS)) begin
            sag_d[ofs +: ADIM_W] = sag_alan + 1'b1;
        end
        if (asagi_bas && (asagi_alan < MAKS)) begin
            asagi_d[ofs +: ADIM_W] = asagi_alan + 1'b1;
        end
        kabul = onay | zaman_doldu;
    end

`ifdef KAPISMA_ZAMAN_ASIMI_EN
    localparam int BOS_W = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [BOS_W-1:0] BOS_SON = BOS_W'(ZAMAN_ASIMI - 1);

    logic [BOS_W-1:0] bos_q;
    logic             hareket;

    assign hareket     = sag_bas | asagi_bas | onay;
    assign zaman_doldu = (durum_q == GIRIS) && !hareket && (bos_q == BOS_SON);

    always_ff @(posedge clk) begin
        if (rst) begin
            bos_q <= '0;
        end else if (durum_q != GIRIS || hareket || zaman_doldu) begin
            bos_q <= '0;
        end else begin
            bos_q <= bos_q + 1'b1;
        end
    end
`else
    assign zaman_doldu = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q   <= BOSTA;
            sag_q     <= '0;
            asagi_q   <= '0;
            sayac_q   <= SAYI_MIN;
            sayi_q    <= '0;
            aktif_q   <= 2'd0;
            gecerli_q <= 1'b0;
            mesgul_q  <= 1'b0;
        end else begin
            sayac_q <= (sayac_q == SAYI_MAX) ? SAYI_MIN : sayac_q + 1'b1;
            unique case (durum_q)
                BOSTA: begin
                    if (basla) begin
                        sayi_q   <= sayac_q;
                        sag_q    <= '0;
                        asagi_q  <= '0;
                        aktif_q  <= 2'd1;
                        mesgul_q <= 1'b1;
                        durum_q  <= GIRIS;
                    end
                end
                GIRIS: begin
                    sag_q   <= sag_d;
                    asagi_q <= asagi_d;
                    if (kabul) begin
                        if (aktif_q == 2'd3) begin
                            aktif_q   <= 2'd0;
                            gecerli_q <= 1'b1;
                            durum_q   <= HAZIR;
                        end else begin
                            aktif_q <= aktif_q + 2'd1;
                        end
                    end
                end
                HAZIR: begin
                    if (sonuc_al) begin
                        gecerli_q <= 1'b0;
                        mesgul_q  <= 1'b0;
                        durum_q   <= BOSTA;
                    end
                end
                default: begin
                    durum_q <= BOSTA;
                end
            endcase
        end
    end

    always_comb begin
        skor_en = 3'b000;
        if (durum_q == HAZIR && sonuc_al) begin
            unique case (kazanan)
                2'd1:    skor_en = 3'b001;
                2'd2:    skor_en = 3'b010;
                2'd3:    skor_en = 3'b100;
                default: skor_en = 3'b000;
            endcase
        end
    end

    kapisma_skor_sayaci #(.SKOR_W(SKOR_W)) u_skor1 (
        .clk  (clk),
        .rst  (rst),
        .en   (skor_en[0]),
        .ekle (toplam_puan),
        .skor (skor1)
    );

    kapisma_skor_sayaci #(.SKOR_W(SKOR_W)) u_skor2 (
        .clk  (clk),
        .rst  (rst),
        .en   (skor_en[1]),
        .ekle (toplam_puan),
        .skor (skor2)
    );

    kapisma_skor_sayaci #(.SKOR_W(SKOR_W)) u_skor3 (
        .clk  (clk),
        .rst  (rst),
        .en   (skor_en[2]),
        .ekle (toplam_puan),
        .skor (skor3)
    );

    assign sag_adimlar   = sag_q;
    assign asagi_adimlar = asagi_q;
    assign sayi          = sayi_q;
    assign gecerli       = gecerli_q;
    assign aktif_oyuncu  = aktif_q;
    assign mesgul        = mesgul_q;

endmodule
